// File: rtl/nx_link_fifo.sv
// -----------------------------------------------------------------------------
// nx_link_fifo
//
// Elastic message buffer on one direction of a mesh node boundary. It sits
// between the sender's outbound stream distributor and the receiver's inbound
// stream arbiter and absorbs back-pressure bursts of up to DEPTH messages.
// When no neighbour exists at this mesh position (present_i tied low) the
// buffer turns into a sink that accepts and discards everything.
//
// Parameters
//   DEPTH        number of message slots (power of two, >= 2)
//   LEVEL_WIDTH  width of level_o, derived as $clog2(DEPTH)+1
//
// Ports
//   clk_i        clock, all state changes on the rising edge
//   rst_i        asynchronous active-low reset
//   wr_data_i    message from the upstream node's outbound port
//   wr_valid_i   upstream message valid
//   wr_ready_o   buffer can accept (registered)
//   present_o    neighbour-present pass-through to the upstream node
//   rd_data_o    message to the downstream node's inbound port
//   rd_valid_o   downstream message valid
//   rd_ready_i   downstream accepts
//   present_i    neighbour exists (static tie-off per mesh position)
//   level_o      current occupancy, 0..DEPTH
//   idle_o       buffer empty and no message offered upstream
//
// Build option
//   NX_LINK_FIFO_BYPASS_EN  when defined, a message offered while the buffer
//                           is empty and the downstream is ready cuts through
//                           combinationally without being stored.
// -----------------------------------------------------------------------------

package nx_link_pkg;
    typedef logic [15:0] nx_message_t;
endpackage

module nx_link_fifo
    import nx_link_pkg::*;
#(
    parameter  int DEPTH       = 4,
    localparam int LEVEL_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  nx_message_t            wr_data_i,
    input  logic                   wr_valid_i,
    output logic                   wr_ready_o,
    output logic                   present_o,
    output nx_message_t            rd_data_o,
    output logic                   rd_valid_o,
    input  logic                   rd_ready_i,
    input  logic                   present_i,
    output logic [LEVEL_WIDTH-1:0] level_o,
    output logic                   idle_o
);

    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam logic [LEVEL_WIDTH-1:0] LEVEL_FULL = LEVEL_WIDTH'(DEPTH);

    nx_message_t            mem_q [DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr_q;
    logic [PTR_WIDTH-1:0]   wr_ptr_d;
    logic [PTR_WIDTH-1:0]   rd_ptr_q;
    logic [PTR_WIDTH-1:0]   rd_ptr_d;
    logic [LEVEL_WIDTH-1:0] level_q;
    logic [LEVEL_WIDTH-1:0] level_d;
    logic                   wr_ready_q;
    logic                   wr_ready_d;

    logic                   empty_s;
    logic                   push_s;
    logic                   bypass_s;
    logic                   store_s;
    logic                   pop_s;
    logic                   rd_valid_s;
    nx_message_t            rd_data_s;

    // Handshake decode: which transfers happen at the coming edge.
    always_comb begin
        empty_s    = (level_q == {LEVEL_WIDTH{1'b0}});
        push_s     = wr_valid_i && wr_ready_q;
`ifdef NX_LINK_FIFO_BYPASS_EN
        // Cut-through only when nothing is queued ahead of the new message,
        // so ordering is preserved. rd_valid never looks at rd_ready_i.
        bypass_s   = present_i && empty_s && push_s && rd_ready_i;
        rd_valid_s = present_i && (!empty_s || push_s);
        if (empty_s) begin
            rd_data_s = wr_data_i;
        end else begin
            rd_data_s = mem_q[rd_ptr_q];
        end
`else
        bypass_s   = 1'b0;
        rd_valid_s = present_i && !empty_s;
        rd_data_s  = mem_q[rd_ptr_q];
`endif
        // In sink mode nothing is stored and nothing is presented.
        store_s    = present_i && push_s && !bypass_s;
        pop_s      = present_i && !empty_s && rd_ready_i;
    end

    // Next-state computation for pointers, occupancy and write-ready.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (store_s) begin
            wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({store_s, pop_s})
            2'b10:   level_d = level_q + LEVEL_WIDTH'(1);
            2'b01:   level_d = level_q - LEVEL_WIDTH'(1);
            default: level_d = level_q;
        endcase
        // Derived from the post-edge level only, so a pop while full frees
        // the slot for the following cycle and rd_ready_i never reaches
        // wr_ready_o combinationally.
        wr_ready_d = (level_d < LEVEL_FULL);
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q   <= {PTR_WIDTH{1'b0}};
            rd_ptr_q   <= {PTR_WIDTH{1'b0}};
            level_q    <= {LEVEL_WIDTH{1'b0}};
            wr_ready_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            wr_ready_q <= wr_ready_d;
        end
    end

    // Message storage; contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (store_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Output assignments.
    always_comb begin
        wr_ready_o = wr_ready_q;
        present_o  = present_i;
        rd_valid_o = rd_valid_s;
        rd_data_o  = rd_data_s;
        level_o    = level_q;
        idle_o     = empty_s && !wr_valid_i;
    end

endmodule
